// File: rtl/turbo_encoder.sv
// turbo_encoder: rate-1/3 LTE parallel-concatenated encoder with two 8-state RSC
// constituents (g0=1+D^2+D^3, g1=1+D+D^3) and per-encoder trellis termination.
module turbo_encoder (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic blocksize,
    input  logic in_valid,
    input  logic sys_in,
    input  logic itl_in,
    output logic d0,
    output logic d1,
    output logic d2,
    output logic out_valid,
    output logic tail,
    output logic busy,
    output logic done
);
    typedef enum logic [1:0] {IDLE, DATA, TAIL1, TAIL2} state_t;
    state_t state, state_nxt;
    logic [12:0] cnt;
    logic [1:0] tcnt;
    logic bs;
    logic [2:0] enc1, enc2;
    logic fb1, fb2, z1, z2, tu1, tu2, tz1, tz2, last_data, tail_end;
    logic [5:0] out_nxt;

    assign fb1 = sys_in ^ enc1[1] ^ enc1[0];
    assign fb2 = itl_in ^ enc2[1] ^ enc2[0];
    assign z1 = fb1 ^ enc1[2] ^ enc1[0];
    assign z2 = fb2 ^ enc2[2] ^ enc2[0];
    // termination input cancels the feedback, so parity reduces to s1^s3
    assign tu1 = enc1[1] ^ enc1[0];
    assign tu2 = enc2[1] ^ enc2[0];
    assign tz1 = enc1[2] ^ enc1[0];
    assign tz2 = enc2[2] ^ enc2[0];
    assign last_data = cnt == (bs ? 13'd6143 : 13'd1055);
    assign tail_end = tcnt == 2'd2;

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? DATA : IDLE;
            DATA:    state_nxt = (in_valid && last_data) ? TAIL1 : DATA;
            TAIL1:   state_nxt = tail_end ? TAIL2 : TAIL1;
            default: state_nxt = tail_end ? IDLE : TAIL2;
        endcase
    end

    // {d0, d1, d2, out_valid, tail, done} presented after the next edge
    always_comb begin
        out_nxt = '0;
        case (state)
            DATA:    out_nxt = in_valid ? {sys_in, z1, z2, 3'b100} : 6'b0;
            TAIL1:   out_nxt = {tu1, tz1, 4'b0110};
            TAIL2:   out_nxt = {tu2, tz2, 3'b011, tail_end};
            default: out_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            {d0, d1, d2, out_valid, tail, done} <= '0;
            busy <= 1'b0;
            bs <= 1'b0;
            cnt <= '0;
            tcnt <= '0;
            enc1 <= '0;
            enc2 <= '0;
        end else begin
            {d0, d1, d2, out_valid, tail, done} <= out_nxt;
            busy <= state_nxt != IDLE;
            case (state)
                IDLE: if (start) begin
                    bs <= blocksize;
                    cnt <= '0;
                    enc1 <= '0;
                    enc2 <= '0;
                end
                DATA: begin
                    tcnt <= '0;
                    if (in_valid) begin
                        enc1 <= {fb1, enc1[2:1]};
                        enc2 <= {fb2, enc2[2:1]};
                        cnt <= last_data ? cnt : cnt + 13'd1;
                    end
                end
                TAIL1: begin
                    enc1 <= {1'b0, enc1[2:1]};
                    tcnt <= tail_end ? 2'd0 : tcnt + 2'd1;
                end
                default: begin
                    enc2 <= {1'b0, enc2[2:1]};
                    tcnt <= tail_end ? 2'd0 : tcnt + 2'd1;
                end
            endcase
        end
endmodule
